// File: rtl/mdu_div_sequencer_pkg.sv
// Shared RV32IM definitions: ALU and divide SELECT codes plus divider FSM states.
// Purely declarative; no latency, no flow control.
package mdu_div_sequencer_pkg;

    localparam logic [4:0] SEL_ADD  = 5'b00000;
    localparam logic [4:0] SEL_SUB  = 5'b00001;
    localparam logic [4:0] SEL_AND  = 5'b00010;
    localparam logic [4:0] SEL_OR   = 5'b00011;
    localparam logic [4:0] SEL_XOR  = 5'b00100;
    localparam logic [4:0] SEL_SLL  = 5'b00101;
    localparam logic [4:0] SEL_SRL  = 5'b00110;
    localparam logic [4:0] SEL_SRA  = 5'b00111;

    localparam logic [4:0] SEL_DIV  = 5'b11100;
    localparam logic [4:0] SEL_DIVU = 5'b11101;
    localparam logic [4:0] SEL_REM  = 5'b11110;
    localparam logic [4:0] SEL_REMU = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    // All four divide codes share the 3'b111 prefix.
    function automatic logic is_div_sel(input logic [4:0] sel);
        return (sel | 5'b00011) == 5'b11111;
    endfunction

endpackage

// File: rtl/mdu_div_sequencer_div_step.sv
// One restoring-division iteration, purely combinational.
// Zero latency; no flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // rem < divisor holds on entry, so a set top bit of diff always means a borrow.
    assign partial  = {rem, quo[WIDTH-1]};
    assign diff     = partial - {1'b0, divisor};
    assign next_rem = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_div_sequencer.sv
// Multi-cycle signed/unsigned divider: 35 cycles start-to-DONE, 2 for div-by-zero/overflow.
// BUSY stalls the pipeline; START is only honoured in IDLE.
module mdu_div_sequencer
    import mdu_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    div_state_t       state, state_nxt;
    logic [1:0]       op;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [5:0]       cnt;
    logic             neg_q, neg_r;
    logic             op_signed, op_quot, div_zero, ovf, last_step;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    assign op_signed = ~op[0];
    assign op_quot   = ~op[1];
    assign div_zero  = (dvsr == '0);
    assign ovf       = op_signed && (quo == {1'b1, {(WIDTH-1){1'b0}}}) && (dvsr == '1);
    assign last_step = (cnt == 6'(WIDTH-1));

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: if (START && is_div_sel(SELECT)) state_nxt = ST_PREP;
            ST_PREP: begin
                BUSY      = 1'b1;
                state_nxt = (div_zero || ovf) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                BUSY = 1'b1;
                if (last_step) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                BUSY      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op     <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            RESULT <= '0;
        end else begin
            case (state)
                ST_IDLE: if (state_nxt == ST_PREP) begin
                    op   <= SELECT[1:0];
                    quo  <= DATA1;
                    dvsr <= DATA2;
                end
                ST_PREP: begin
                    // quo still holds the raw dividend here.
                    if (div_zero) begin
                        RESULT <= op_quot ? '1 : quo;
                    end else if (ovf) begin
                        RESULT <= op_quot ? quo : '0;
                    end else begin
                        neg_q <= op_signed & (quo[WIDTH-1] ^ dvsr[WIDTH-1]);
                        neg_r <= op_signed & quo[WIDTH-1];
                        if (op_signed && quo[WIDTH-1])  quo  <= -quo;
                        if (op_signed && dvsr[WIDTH-1]) dvsr <= -dvsr;
                        rem <= '0;
                        cnt <= '0;
                    end
                end
                ST_CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + 6'd1;
                end
                ST_FIX: begin
                    if (op_quot) RESULT <= neg_q ? -quo : quo;
                    else         RESULT <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// Directed and random checks of mdu_div_sequencer against an arithmetic reference model.
module tb_mdu_div_sequencer;
    import mdu_div_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, START;
    logic [4:0]  SELECT;
    logic [31:0] DATA1, DATA2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_prev = '0;

    mdu_div_sequencer #(.WIDTH(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 0) return (sel == SEL_DIV || sel == SEL_DIVU) ? 32'hFFFF_FFFF : a;
        if (sel == SEL_DIV || sel == SEL_REM) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return (sel == SEL_DIV || sel == SEL_DIVU) ? qv[31:0] : rv[31:0];
    endfunction

    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat, k;
        logic        busy_ok, hold_ok;
        exp     = ref_div(sel, a, b);
        exp_lat = is_special(sel, a, b) ? 2 : 35;
        SELECT  = sel;
        DATA1   = a;
        DATA2   = b;
        START   = 1'b1;
        @(negedge CLK);
        START   = 1'b0;
        DATA1   = $urandom;
        DATA2   = $urandom;
        k       = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!DONE && k < 40) begin
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            if (RESULT !== exp_prev) hold_ok = 1'b0;
            @(negedge CLK);
            k++;
        end
        check({tag, "/latency"}, k, exp_lat);
        check({tag, "/result"}, RESULT, exp);
        check({tag, "/busy_during"}, {31'b0, busy_ok}, 32'd1);
        check({tag, "/result_held"}, {31'b0, hold_ok}, 32'd1);
        check({tag, "/busy_at_done"}, {31'b0, BUSY}, 32'd0);
        exp_prev = exp;
        @(negedge CLK);
        check({tag, "/done_one_cycle"}, {31'b0, DONE}, 32'd0);
        check({tag, "/result_after"}, RESULT, exp);
    endtask

    initial begin
        int dones;
        logic [4:0]  rs;
        logic [31:0] ra, rb;

        RESET  = 1'b1;
        START  = 1'b0;
        SELECT = SEL_ADD;
        DATA1  = '0;
        DATA2  = '0;
        repeat (2) @(negedge CLK);
        check("reset/busy", {31'b0, BUSY}, 32'd0);
        check("reset/done", {31'b0, DONE}, 32'd0);
        check("reset/result", RESULT, 32'd0);

        // Reset wins over a simultaneous START.
        START  = 1'b1;
        SELECT = SEL_DIV;
        DATA1  = 32'd100;
        DATA2  = 32'd7;
        @(negedge CLK);
        check("rst_prio/busy", {31'b0, BUSY}, 32'd0);
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        check("rst_prio/idle", {31'b0, BUSY}, 32'd0);

        run_op(SEL_DIV,  32'd100, 32'd7, "div_100_7");
        run_op(SEL_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(SEL_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(SEL_DIVU, 32'hFFFF_FFFF, 32'd2, "divu_max_2");
        run_op(SEL_REMU, 32'hFFFF_FFFF, 32'd2, "remu_max_2");
        run_op(SEL_DIV,  32'd5, 32'd0, "div_by_zero");
        run_op(SEL_REM,  32'd5, 32'd0, "rem_by_zero");
        run_op(SEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(SEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(SEL_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");

        // Non-divide SELECT with START must leave the block idle.
        SELECT = SEL_XOR;
        DATA1  = 32'd77;
        DATA2  = 32'd3;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("alu_sel/busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        check("alu_sel/done", {31'b0, DONE}, 32'd0);
        check("alu_sel/result", RESULT, exp_prev);

        // Reset in the 10th CALC cycle (cycle 11 after the start edge).
        SELECT = SEL_DIV;
        DATA1  = 32'd100;
        DATA2  = 32'd7;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mid_reset/busy", {31'b0, BUSY}, 32'd0);
        check("mid_reset/done", {31'b0, DONE}, 32'd0);
        check("mid_reset/result", RESULT, 32'd0);
        exp_prev = '0;
        run_op(SEL_DIVU, 32'd9, 32'd3, "divu_after_reset");

        // START held every cycle with changing operands, including through DONE.
        SELECT = SEL_DIV;
        DATA1  = 32'd1000;
        DATA2  = 32'd10;
        START  = 1'b1;
        dones  = 0;
        for (int k = 0; k < 40 && dones == 0; k++) begin
            @(negedge CLK);
            if (DONE) dones++;
            SELECT = SEL_DIV + 5'($urandom_range(0, 3));
            DATA1  = $urandom;
            DATA2  = $urandom;
        end
        check("restart/result", RESULT, 32'd100);
        @(negedge CLK);
        check("restart/done_ignored", {31'b0, BUSY}, 32'd0);
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        check("restart/done_pulses", dones, 32'd1);
        exp_prev = 32'd100;

        for (int i = 0; i < 16; i++) begin
            rs = SEL_DIV + 5'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rs, ra, rb, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
